// File: rtl/servant_uart_pkg.sv
// Shared types and constants for the servant UART transmitter.
//   tx_state_t     : serializer FSM states
//   ST_*           : bit positions inside the 32-bit status word
package servant_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_LVL_LSB = 8;

endpackage

// File: rtl/servant_uart_fifo.sv
// Synchronous FIFO with first-word fall-through read.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_dat  : write strobe and data (ignored while full)
//   i_pop          : read strobe, o_dat advances next cycle (ignored while empty)
//   o_dat          : entry at the read pointer
//   o_full/o_empty : occupancy flags
//   o_level        : number of stored entries
module servant_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_dat,
  output logic [WIDTH-1:0]         o_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra MSB so full (MSBs differ) and empty (equal)
  // are distinguishable when the index bits match.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign o_level = wptr_q - rptr_q;
  assign o_dat   = mem[rptr_q[AW-1:0]];

  always_comb begin
    do_push = i_push & ~o_full;
    do_pop  = i_pop & ~o_empty;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define
  // which entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/servant_uart_tx.sv
// Wishbone-attached buffered 8N1 UART transmitter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_wb_cyc       : bus cycle, one action per rising edge of cyc
//   i_wb_we        : 1 = write byte into FIFO, 0 = status read (clears ovf)
//   i_wb_dat       : byte to transmit
//   o_wb_rdt       : status {level[15:8], ovf, empty, full, busy}
//   o_tx           : serial line, idles high
//   o_irq          : high while FIFO empty and serializer idle
module servant_uart_tx
  import servant_uart_pkg::*;
#(
  parameter int DIVISOR = 278,
  parameter int DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [7:0]  i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int          LW          = $clog2(DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        cyc_q, cyc_d;
  logic        ovf_q, ovf_d;

  logic          start, wr_start, rd_start;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dat;
  logic [LW-1:0] level;

  // A held cyc only counts on its first cycle.
  assign start    = i_wb_cyc & ~cyc_q;
  assign wr_start = start & i_wb_we;
  assign rd_start = start & ~i_wb_we;
  // Full is judged before any same-cycle pop, so a write to a full FIFO
  // is dropped even while the serializer is draining it.
  assign push     = wr_start & ~fifo_full;

  servant_uart_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_dat   (i_wb_dat),
    .o_dat   (fifo_dat),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (level)
  );

  always_comb begin
    cyc_d = i_wb_cyc;
    ovf_d = ovf_q;
    if (wr_start && fifo_full) ovf_d = 1'b1;
    else if (rd_start)         ovf_d = 1'b0;
  end

  // Serializer: every bit lasts DIVISOR cycles (baud_q counts DIVISOR-1..0).
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dat;
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == 16'd0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_q == 16'd0) begin
          baud_d  = BAUD_RELOAD;
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_q == 16'd0) state_d = IDLE;
        else                 baud_d  = baud_q - 16'd1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cyc_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cyc_q   <= cyc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    case (state_q)
      START:   o_tx = 1'b0;
      DATA:    o_tx = shreg_q[0];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_irq = fifo_empty & (state_q == IDLE);

  always_comb begin
    o_wb_rdt                      = '0;
    o_wb_rdt[ST_BUSY]             = (state_q != IDLE);
    o_wb_rdt[ST_FULL]             = fifo_full;
    o_wb_rdt[ST_EMPTY]            = fifo_empty;
    o_wb_rdt[ST_OVF]              = ovf_q;
    o_wb_rdt[ST_LVL_LSB +: 8]     = 8'(level);
  end

endmodule

// File: tb/tb_servant_uart_tx.sv
// Self-checking bench for servant_uart_tx (DIVISOR = 4, DEPTH = 8).
// The reference model tracks each accepted byte by its push edge and the
// edge it is scheduled to leave the FIFO; a line monitor decodes o_tx cycle
// by cycle against that schedule.
module tb_servant_uart_tx;

  localparam int D     = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * D;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc   = 1'b0;
  logic        we    = 1'b0;
  logic [7:0]  dat   = 8'h00;
  logic [31:0] rdt;
  logic        tx;
  logic        irq;

  always #5 clk = ~clk;

  servant_uart_tx #(
    .DIVISOR (D),
    .DEPTH   (DEPTH)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wb_cyc (cyc),
    .i_wb_we  (we),
    .i_wb_dat (dat),
    .o_wb_rdt (rdt),
    .o_tx     (tx),
    .o_irq    (irq)
  );

  int checks   = 0;
  int failures = 0;
  int cnt      = 0;   // index of the most recent rising edge

  always @(posedge clk) cnt <= cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp_v, cnt);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] b;
    int         pop;
  } exp_t;

  int   push_e[$];
  int   pop_e[$];
  exp_t exp_q[$];
  int   last_pop = -100000;
  bit   ovf_m    = 1'b0;
  int   fall_log[$];

  function automatic int level_after(input int c);
    int n = 0;
    for (int i = 0; i < push_e.size(); i++)
      if (push_e[i] <= c && pop_e[i] > c) n++;
    return n;
  endfunction

  function automatic bit busy_after(input int c);
    for (int i = 0; i < pop_e.size(); i++)
      if (pop_e[i] <= c && c < pop_e[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_status(input int c, input bit ovf);
    int lvl;
    lvl = level_after(c);
    return {16'h0, 8'(lvl), 4'h0, ovf, (lvl == 0), (lvl == DEPTH), busy_after(c)};
  endfunction

  task automatic clear_model();
    push_e.delete();
    pop_e.delete();
    exp_q.delete();
    last_pop = -100000;
    ovf_m    = 1'b0;
  endtask

  // Status (minus sticky ovf) and irq are checked every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("status", rdt & ~32'h8, exp_status(cnt, 1'b0));
      check("irq", {31'h0, irq}, {31'h0, (level_after(cnt) == 0) && !busy_after(cnt)});
    end
  end

  // Line monitor: every cycle of a frame is compared with the expected bit.
  bit         mon_act = 1'b0;
  int         mon_p;
  logic [7:0] mon_b;
  int         mon_off, mon_idx;
  logic       mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        fall_log.push_back(cnt);
        check("start_pending", {31'h0, exp_q.size() > 0}, 32'h1);
        mon_b = 8'h00;
        if (exp_q.size() > 0) begin
          check("start_edge", cnt, exp_q[0].pop);
          mon_b = exp_q[0].b;
          void'(exp_q.pop_front());
        end
        mon_act = 1'b1;
        mon_p   = cnt;
      end
    end else begin
      mon_off = cnt - mon_p;
      mon_idx = mon_off / D;
      if (mon_idx == 0)      mon_exp = 1'b0;
      else if (mon_idx == 9) mon_exp = 1'b1;
      else                   mon_exp = mon_b[mon_idx-1];
      check($sformatf("tx_bit%0d_byte%h", mon_idx, mon_b), {31'h0, tx}, {31'h0, mon_exp});
      if (mon_off == FRAME - 1) mon_act = 1'b0;
    end
  end

  // ---------------- bus drivers ----------------
  // Drives one write; n is the rising edge at which it is decided. Returns
  // at the negedge after cyc has been held for 'hold' cycles.
  task automatic do_write(input logic [7:0] b, input int hold, output int n);
    int p;
    @(negedge clk);
    n   = cnt + 1;
    cyc = 1'b1;
    we  = 1'b1;
    dat = b;
    if (level_after(n - 1) >= DEPTH) begin
      ovf_m = 1'b1;
    end else begin
      p = n + 1;
      if (last_pop + FRAME + 1 > p) p = last_pop + FRAME + 1;
      push_e.push_back(n);
      pop_e.push_back(p);
      exp_q.push_back('{b, p});
      last_pop = p;
    end
    repeat (hold) @(negedge clk);
    cyc = 1'b0;
    we  = 1'b0;
  endtask

  task automatic do_read(input string name, output logic [31:0] st);
    @(negedge clk);
    cyc = 1'b1;
    we  = 1'b0;
    #1;
    st = rdt;
    check(name, st, exp_status(cnt, ovf_m));
    @(negedge clk);
    cyc   = 1'b0;
    ovf_m = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || mon_act) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'h0, k < budget}, 32'h1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] dat;
    int         lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          n, n2, nf;
    logic [31:0] st;

    // Burst table: byte 0 leaves at once, bytes 1..8 fill the FIFO,
    // bytes 9 and 10 are dropped.
    for (int i = 0; i < 11; i++)
      vecs[i] = '{8'(i), (i == 0) ? 1 : ((i > 8) ? 8 : i), (i > 8)};

    // Reset values.
    #1;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h1);
    check("rst_rdt", rdt, 32'h0000_0004);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: start bit 2 cycles after the start cycle, irq back 40 later.
    do_write(8'hA5, 1, n);
    check("a5_tx_idle_e1", {31'h0, tx}, 32'h1);
    @(negedge clk);
    check("a5_tx_start_e2", {31'h0, tx}, 32'h0);
    repeat (39) @(negedge clk);
    check("a5_irq_low_end", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check("a5_irq_high", {31'h0, irq}, 32'h1);
    drain("a5_drain", 200);

    // Burst to full.
    for (int i = 0; i < 11; i++) begin
      do_write(vecs[i].dat, 1, n);
      check($sformatf("burst%0d_level", i), {24'h0, rdt[15:8]}, vecs[i].lvl);
      check($sformatf("burst%0d_ovf", i), {31'h0, rdt[3]}, {31'h0, vecs[i].ovf});
    end
    do_read("burst_read1", st);
    check("burst_full", {31'h0, st[1]}, 32'h1);
    check("burst_lvl8", {24'h0, st[15:8]}, 32'd8);
    check("burst_ovf_set", {31'h0, st[3]}, 32'h1);
    do_read("burst_read2", st);
    check("burst_ovf_clr", {31'h0, st[3]}, 32'h0);
    drain("burst_drain", 1000);

    // Long cyc: one push only.
    nf = fall_log.size();
    do_write(8'h3C, 5, n);
    check("longcyc_level", {24'h0, rdt[15:8]}, 32'd0);
    check("longcyc_busy", {31'h0, rdt[0]}, 32'h1);
    drain("longcyc_drain", 200);
    check("longcyc_frames", fall_log.size() - nf, 32'd1);

    // Back-to-back frames.
    do_write(8'h55, 1, n);
    do_write(8'hFF, 1, n2);
    drain("b2b_drain", 300);
    check("b2b_period", fall_log[fall_log.size()-1] - fall_log[fall_log.size()-2], FRAME + 1);

    // Asynchronous reset during data bit 3.
    do_write(8'hC3, 1, n);
    while (cnt < n + 1 + 4 * D + 1) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("midrst_tx", {31'h0, tx}, 32'h1);
    check("midrst_rdt", rdt, 32'h0000_0004);
    check("midrst_irq", {31'h0, irq}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_write(8'h81, 1, n);
    drain("post_rst_drain", 200);

    // Pointer wrap: 20 paced random bytes, FIFO never fills.
    for (int i = 0; i < 20; i++) begin
      do_write(8'($urandom), 1, n);
      repeat ($urandom_range(30, 60)) @(negedge clk);
    end
    drain("wrap_drain", 600);
    do_read("wrap_read", st);
    check("wrap_no_ovf", {31'h0, st[3]}, 32'h0);

    // Random mix of writes (with long cyc) and status reads, overflow allowed.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) do_read("rand_read", st);
      else do_write(8'($urandom), int'($urandom_range(1, 3)), n);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    do_read("rand_read_end", st);
    drain("rand_drain", 3000);
    do_read("final_read", st);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
